// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the bypassing register file.
//   rf_state_t    : lifecycle of the file (clear sweep, then ready for use)
//   XLEN_DEF      : default data width
//   ADDR_W_DEF    : default register address width
//   RF_ADDR_MAX_W : width that rf_hit compares at; callers zero-extend to it
//   rf_hit        : two register addresses name the same real (non-x0) register
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int XLEN_DEF      = 64;
    localparam int ADDR_W_DEF    = 5;
    localparam int RF_ADDR_MAX_W = 16;

    // x0 never matches anything: it is hardwired and has no producer.
    function automatic logic rf_hit(input logic [RF_ADDR_MAX_W-1:0] addr_a,
                                    input logic [RF_ADDR_MAX_W-1:0] addr_b);
        return (addr_a == addr_b) && (addr_a != {RF_ADDR_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_bypass_scoreboard.sv
// Busy scoreboard: one bit per register, set by issue, cleared by writeback.
//   clk, rst     : clock and synchronous active-high reset (clears all bits)
//   clear_all    : synchronous clear of every bit (held while the file is not ready)
//   set_en/addr  : mark a destination as having an outstanding producer
//   clr_en/addr  : retire the producer of a register
//   lookup_addr  : NREAD packed read addresses
//   lookup_busy  : busy bit of each looked-up register
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_all,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NREAD*ADDR_W-1:0] lookup_addr,
    output logic [NREAD-1:0]        lookup_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_next_s;

    // Next busy vector: clear first so that a same-cycle issue to the same
    // register (a newer producer) overrides the retiring one.
    always_comb begin
        busy_next_s = busy_r;
        if (clr_en) begin
            busy_next_s[clr_addr] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (set_en && (set_addr != {ADDR_W{1'b0}})) begin
            busy_next_s[set_addr] = 1'b1;
        end else begin
            busy_next_s[0] = busy_next_s[0];
        end
        busy_next_s[0] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Independent lookup per read port.
    always_comb begin
        lookup_busy = {NREAD{1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            lookup_busy[i] = busy_r[lookup_addr[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port integer register file with hardwired x0, write-to-read bypass,
// busy scoreboard and a post-reset zeroing sweep.
//   clk, rst   : clock, synchronous active-high reset
//   readAddr   : NREAD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   readData   : NREAD packed read data, combinational from readAddr
//   readBusy   : per-port "source has an outstanding producer"
//   addressw, writeData, writeEn : writeback port
//   issueAddr, issueEn           : destination of a newly issued instruction
//   ready      : sweep finished, writes and issues are accepted
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int NREAD          = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] readAddr,
    output logic [NREAD*XLEN-1:0]   readData,
    output logic [NREAD-1:0]        readBusy,
    input  logic [ADDR_W-1:0]       addressw,
    input  logic [XLEN-1:0]         writeData,
    input  logic                    writeEn,
    input  logic [ADDR_W-1:0]       issueAddr,
    input  logic                    issueEn,
    output logic                    ready
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state_r;
    rf_state_t         state_next_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_next_s;
    logic              ready_r;
    logic              sweep_we_s;

    logic [XLEN-1:0]   mem_r [DEPTH];
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [XLEN-1:0]   wr_data_s;

    logic [ADDR_W-1:0] raddr_s [NREAD];
    logic [NREAD-1:0]  lookup_busy_s;

    // Sweep FSM: next state, next sweep index and sweep write strobe.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        sweep_we_s   = 1'b0;
        case (state_r)
            RF_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    sweep_we_s = 1'b1;
                    idx_next_s = idx_r + ADDR_W'(1'b1);
                    if (idx_r == LAST_IDX) begin
                        state_next_s = RF_READY;
                    end else begin
                        state_next_s = RF_CLEAR;
                    end
                end else begin
                    // No sweep: contents are left as they were.
                    state_next_s = RF_READY;
                end
            end
            RF_READY: begin
                state_next_s = RF_READY;
            end
            default: begin
                state_next_s = RF_CLEAR;
            end
        endcase
    end

    // FSM state, sweep index and registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RF_CLEAR;
            idx_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            ready_r <= (state_next_s == RF_READY);
        end
    end

    assign ready = ready_r;

    // Single storage write port shared by the sweep and writeback.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = idx_r;
        wr_data_s = {XLEN{1'b0}};
        if (rst) begin
            wr_en_s = 1'b0;
        end else if (sweep_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = idx_r;
            wr_data_s = {XLEN{1'b0}};
        end else if (ready_r && writeEn && (addressw != {ADDR_W{1'b0}})) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addressw;
            wr_data_s = writeData;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array; deliberately not reset, the sweep provides the zeroing.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end else begin
            mem_r[wr_addr_s] <= mem_r[wr_addr_s];
        end
    end

    // Scoreboard is held clear for as long as the file is not ready.
    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clear_all   (~ready_r),
        .set_en      (ready_r & issueEn),
        .set_addr    (issueAddr),
        .clr_en      (ready_r & writeEn),
        .clr_addr    (addressw),
        .lookup_addr (readAddr),
        .lookup_busy (lookup_busy_s)
    );

    // Unpack the read addresses.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            raddr_s[i] = readAddr[i*ADDR_W +: ADDR_W];
        end
    end

    // Read mux: x0, then forwarded writeback data, then storage.
    always_comb begin
        readData = {(NREAD*XLEN){1'b0}};
        readBusy = {NREAD{1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            if (!ready_r) begin
                readData[i*XLEN +: XLEN] = {XLEN{1'b0}};
                readBusy[i]              = 1'b0;
            end else if (raddr_s[i] == {ADDR_W{1'b0}}) begin
                readData[i*XLEN +: XLEN] = {XLEN{1'b0}};
                readBusy[i]              = 1'b0;
            end else if ((BYPASS != 0) && writeEn &&
                         rf_hit(RF_ADDR_MAX_W'(addressw), RF_ADDR_MAX_W'(raddr_s[i]))) begin
                // The value being written back is the one this reader wants,
                // so its producer is effectively complete.
                readData[i*XLEN +: XLEN] = writeData;
                readBusy[i]              = 1'b0;
            end else begin
                readData[i*XLEN +: XLEN] = mem_r[raddr_s[i]];
                readBusy[i]              = lookup_busy_s[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  readAddr;
    logic [4:0]  addressw;
    logic [63:0] writeData;
    logic        writeEn;
    logic [4:0]  issueAddr;
    logic        issueEn;

    logic [127:0] rd_a, rd_b;
    logic [1:0]   rb_a, rb_b;
    logic         ready_a, ready_b;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    regfile_bypass #(.XLEN(64), .ADDR_W(5), .NREAD(2), .BYPASS(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .readAddr(readAddr), .readData(rd_a), .readBusy(rb_a),
        .addressw(addressw), .writeData(writeData), .writeEn(writeEn),
        .issueAddr(issueAddr), .issueEn(issueEn), .ready(ready_a)
    );

    regfile_bypass #(.XLEN(64), .ADDR_W(5), .NREAD(2), .BYPASS(0), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .readAddr(readAddr), .readData(rd_b), .readBusy(rb_b),
        .addressw(addressw), .writeData(writeData), .writeEn(writeEn),
        .issueAddr(issueAddr), .issueEn(issueEn), .ready(ready_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        readAddr  = 10'd0;
        addressw  = 5'd0;
        writeData = 64'd0;
        writeEn   = 1'b0;
        issueAddr = 5'd0;
        issueEn   = 1'b0;

        // Reset for one cycle, then count cycles until ready.
        tick();
        rst = 1'b0;
        check("reset_ready", {63'd0, ready_a}, 64'd0);
        // Attempted write/issue/read while sweeping must all be inert.
        writeEn   = 1'b1;
        addressw  = 5'd1;
        writeData = 64'hDEAD_BEEF_0000_0001;
        issueEn   = 1'b1;
        issueAddr = 5'd2;
        readAddr  = {5'd2, 5'd1};
        #1;
        check("sweep_rd0", rd_a[63:0], 64'd0);
        check("sweep_busy", {62'd0, rb_a}, 64'd0);
        n = 0;
        while ((ready_a !== 1'b1) && (n < 100)) begin
            tick();
            n++;
        end
        writeEn = 1'b0;
        issueEn = 1'b0;
        check("sweep_len", 64'(n), 64'd32);
        check("ready_b", {63'd0, ready_b}, 64'd1);

        // Every register reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            readAddr = {5'(31 - i), 5'(i)};
            #1;
            check("clr_p0", rd_a[63:0], 64'd0);
            check("clr_p1", rd_a[127:64], 64'd0);
        end
        readAddr = {5'd0, 5'd2};
        #1;
        check("sweep_issue_dropped", {62'd0, rb_a}, 64'd0);

        // Plain writes then read back on both ports.
        writeEn   = 1'b1;
        addressw  = 5'd1;
        writeData = 64'h1234567890ABCDEF;
        readAddr  = 10'd0;
        tick();
        addressw  = 5'd2;
        writeData = 64'hFEDCBA0987654321;
        tick();
        writeEn   = 1'b0;
        readAddr  = {5'd2, 5'd1};
        #1;
        check("wr_x1", rd_a[63:0], 64'h1234567890ABCDEF);
        check("wr_x2", rd_a[127:64], 64'hFEDCBA0987654321);
        readAddr  = {5'd1, 5'd1};
        #1;
        check("shared_p1", rd_a[127:64], 64'h1234567890ABCDEF);

        // Same-cycle write and read of x3.
        writeEn   = 1'b1;
        addressw  = 5'd3;
        writeData = 64'hA5A5;
        readAddr  = {5'd1, 5'd3};
        #1;
        check("bypass_on", rd_a[63:0], 64'hA5A5);
        check("bypass_off", rd_b[63:0], 64'd0);
        check("bypass_other_port", rd_a[127:64], 64'h1234567890ABCDEF);
        tick();
        writeEn = 1'b0;
        #1;
        check("x3_after_a", rd_a[63:0], 64'hA5A5);
        check("x3_after_b", rd_b[63:0], 64'hA5A5);

        // x0 is hardwired: writes dropped, never busy.
        writeEn   = 1'b1;
        addressw  = 5'd0;
        writeData = 64'hFFFF;
        readAddr  = 10'd0;
        #1;
        check("x0_bypass", rd_a[63:0], 64'd0);
        tick();
        writeEn   = 1'b0;
        issueEn   = 1'b1;
        issueAddr = 5'd0;
        tick();
        issueEn   = 1'b0;
        #1;
        check("x0_p0", rd_a[63:0], 64'd0);
        check("x0_p1", rd_a[127:64], 64'd0);
        check("x0_busy", {62'd0, rb_a}, 64'd0);

        // Scoreboard on x5.
        issueEn   = 1'b1;
        issueAddr = 5'd5;
        readAddr  = {5'd5, 5'd5};
        #1;
        check("busy_not_yet", {62'd0, rb_a}, 64'd0);
        tick();
        issueEn = 1'b0;
        #1;
        check("busy_set", {62'd0, rb_a}, 64'd3);
        issueEn   = 1'b1;
        writeEn   = 1'b1;
        addressw  = 5'd5;
        writeData = 64'h77;
        #1;
        check("busy_masked_a", {62'd0, rb_a}, 64'd0);
        check("busy_unmasked_b", {62'd0, rb_b}, 64'd3);
        tick();
        issueEn = 1'b0;
        writeEn = 1'b0;
        #1;
        check("set_wins", {62'd0, rb_a}, 64'd3);
        check("x5_val", rd_a[63:0], 64'h77);
        writeEn   = 1'b1;
        writeData = 64'h88;
        tick();
        writeEn = 1'b0;
        #1;
        check("busy_cleared", {62'd0, rb_a}, 64'd0);
        check("x5_val2", rd_a[127:64], 64'h88);

        // Reset in the middle of a sweep restarts it from scratch.
        issueEn   = 1'b1;
        issueAddr = 5'd7;
        tick();
        issueEn  = 1'b0;
        readAddr = {5'd1, 5'd7};
        #1;
        check("busy_x7", {62'd0, rb_a}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mid_sweep_ready", {63'd0, ready_a}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while ((ready_a !== 1'b1) && (n < 100)) begin
            tick();
            n++;
        end
        check("resweep_len", 64'(n), 64'd32);
        check("resweep_busy", {62'd0, rb_a}, 64'd0);
        check("resweep_x1", rd_a[127:64], 64'd0);
        readAddr = {5'd5, 5'd3};
        #1;
        check("resweep_x3", rd_a[63:0], 64'd0);
        check("resweep_x5", rd_a[127:64], 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
